// File: rtl/arm_pkg.sv
// Shared encodings for the execute stage: ALU opcodes, ARM condition codes,
// NZCV flag bit positions and the condition-evaluation helper.
package arm_pkg;

  typedef enum logic [3:0] {
    ALU_ADD = 4'b0000,
    ALU_SUB = 4'b0001,
    ALU_AND = 4'b0010,
    ALU_ORR = 4'b0011,
    ALU_EOR = 4'b0100,
    ALU_MOV = 4'b0101,
    ALU_MVN = 4'b0110
  } alu_op_t;

  typedef enum logic [3:0] {
    COND_EQ = 4'b0000, COND_NE = 4'b0001, COND_CS = 4'b0010, COND_CC = 4'b0011,
    COND_MI = 4'b0100, COND_PL = 4'b0101, COND_VS = 4'b0110, COND_VC = 4'b0111,
    COND_HI = 4'b1000, COND_LS = 4'b1001, COND_GE = 4'b1010, COND_LT = 4'b1011,
    COND_GT = 4'b1100, COND_LE = 4'b1101, COND_AL = 4'b1110, COND_NV = 4'b1111
  } cond_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // Which flags an opcode actually produces; unused opcodes produce none.
  function automatic logic [3:0] alu_flag_mask(input logic [3:0] op);
    case (op)
      ALU_ADD, ALU_SUB:                            alu_flag_mask = 4'b1111;
      ALU_AND, ALU_ORR, ALU_EOR, ALU_MOV, ALU_MVN: alu_flag_mask = 4'b1100;
      default:                                     alu_flag_mask = 4'b0000;
    endcase
  endfunction

  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] flags);
    logic n, z, c, v;
    n = flags[FLAG_N];
    z = flags[FLAG_Z];
    c = flags[FLAG_C];
    v = flags[FLAG_V];
    case (cond)
      COND_EQ: cond_pass = z;
      COND_NE: cond_pass = ~z;
      COND_CS: cond_pass = c;
      COND_CC: cond_pass = ~c;
      COND_MI: cond_pass = n;
      COND_PL: cond_pass = ~n;
      COND_VS: cond_pass = v;
      COND_VC: cond_pass = ~v;
      COND_HI: cond_pass = c & ~z;
      COND_LS: cond_pass = ~c | z;
      COND_GE: cond_pass = (n == v);
      COND_LT: cond_pass = (n != v);
      COND_GT: cond_pass = ~z & (n == v);
      COND_LE: cond_pass = z | (n != v);
      COND_AL: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/exe_alu.sv
// Combinational ALU: 33-bit add/subtract plus logic ops, producing result and NZCV.
module exe_alu
  import arm_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [3:0]    op,
  input  logic          cin,
  output logic [DW-1:0] result,
  output logic [3:0]    flags
);

  logic [DW:0]   sum;
  logic [DW-1:0] addend;
  logic          carry_in;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    addend   = b;
    carry_in = cin;
    if (op == ALU_SUB) begin
      addend   = ~b;
      carry_in = 1'b1;
    end
  end

  assign sum = {1'b0, a} + {1'b0, addend} + {{DW{1'b0}}, carry_in};

  always_comb begin
    result = '0;
    case (op)
      ALU_ADD, ALU_SUB: result = sum[DW-1:0];
      ALU_AND:          result = a & b;
      ALU_ORR:          result = a | b;
      ALU_EOR:          result = a ^ b;
      ALU_MOV:          result = b;
      ALU_MVN:          result = ~b;
      default:          result = '0;
    endcase
  end

  always_comb begin
    flags         = '0;
    flags[FLAG_N] = result[DW-1];
    flags[FLAG_Z] = (result == '0);
    flags[FLAG_C] = sum[DW];
    flags[FLAG_V] = (a[DW-1] == addend[DW-1]) & (sum[DW-1] != a[DW-1]);
  end

endmodule

// File: rtl/exe_cond_stage.sv
// Execute stage: ALU, condition check against the NZCV register, branch resolution
// and the EX/MEM pipeline register. Failed conditions suppress every side effect.
module exe_cond_stage
  import arm_pkg::*;
#(
  parameter int DW = 32,
  parameter int RW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stallE,
  input  logic          flushE,
  input  logic [DW-1:0] dataRegA,
  input  logic [DW-1:0] dataRegB,
  input  logic [DW-1:0] ext,
  input  logic          ALUSrcE,
  input  logic [3:0]    ALUControlE,
  input  logic          PlusOneE,
  input  logic [3:0]    flagWriteE,
  input  logic [3:0]    CondE,
  input  logic [RW-1:0] WA3E,
  input  logic          RegWriteE,
  input  logic          MemToRegE,
  input  logic          PCSrcE,
  input  logic          BranchE,
  output logic          branchTakenE,
  output logic [DW-1:0] branchTargetE,
  output logic [DW-1:0] aluResultM,
  output logic [DW-1:0] writeDataM,
  output logic [RW-1:0] WA3M,
  output logic          RegWriteM,
  output logic          MemToRegM,
  output logic          PCSrcM,
  output logic [3:0]    flagsM
);

  logic [DW-1:0] src_b;
  logic [DW-1:0] alu_result;
  logic [3:0]    alu_flags;
  logic          cond_ex;
  logic [3:0]    flag_we;

  logic [3:0]    flags_q, flags_d;
  logic [DW-1:0] alu_result_q, alu_result_d;
  logic [DW-1:0] write_data_q, write_data_d;
  logic [RW-1:0] wa3_q, wa3_d;
  logic          reg_write_q, reg_write_d;
  logic          mem_to_reg_q, mem_to_reg_d;
  logic          pc_src_q, pc_src_d;

  assign src_b = ALUSrcE ? ext : dataRegB;

  exe_alu #(.DW(DW)) u_alu (
    .a      (dataRegA),
    .b      (src_b),
    .op     (ALUControlE),
    .cin    (PlusOneE),
    .result (alu_result),
    .flags  (alu_flags)
  );

  // Condition sees the flags as they stand before this instruction writes them.
  assign cond_ex       = cond_pass(CondE, flags_q);
  assign branchTakenE  = BranchE & cond_ex & ~flushE;
  assign branchTargetE = alu_result;

  assign flag_we = flagWriteE & alu_flag_mask(ALUControlE)
                 & {4{cond_ex & ~stallE & ~flushE}};

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      flags_d[i] = flag_we[i] ? alu_flags[i] : flags_q[i];
    end
  end

  always_comb begin
    alu_result_d = alu_result_q;
    write_data_d = write_data_q;
    wa3_d        = wa3_q;
    reg_write_d  = reg_write_q;
    mem_to_reg_d = mem_to_reg_q;
    pc_src_d     = pc_src_q;
    if (flushE) begin
      alu_result_d = '0;
      write_data_d = '0;
      wa3_d        = '0;
      reg_write_d  = 1'b0;
      mem_to_reg_d = 1'b0;
      pc_src_d     = 1'b0;
    end else if (!stallE) begin
      alu_result_d = alu_result;
      write_data_d = dataRegB;
      wa3_d        = WA3E;
      reg_write_d  = RegWriteE & cond_ex;
      mem_to_reg_d = MemToRegE;
      pc_src_d     = PCSrcE & cond_ex;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    if (rst) begin
      flags_q      <= '0;
      alu_result_q <= '0;
      write_data_q <= '0;
      wa3_q        <= '0;
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      pc_src_q     <= 1'b0;
    end else begin
      flags_q      <= flags_d;
      alu_result_q <= alu_result_d;
      write_data_q <= write_data_d;
      wa3_q        <= wa3_d;
      reg_write_q  <= reg_write_d;
      mem_to_reg_q <= mem_to_reg_d;
      pc_src_q     <= pc_src_d;
    end
  end

  assign aluResultM = alu_result_q;
  assign writeDataM = write_data_q;
  assign WA3M       = wa3_q;
  assign RegWriteM  = reg_write_q;
  assign MemToRegM  = mem_to_reg_q;
  assign PCSrcM     = pc_src_q;
  assign flagsM     = flags_q;

endmodule
